// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Status/Cause/EPC/EBase/BadVAddr/Count/Compare,
// mtc0/mfc0 access, exception entry/return bookkeeping and interrupt request.
package cp0_pkg;
   typedef enum logic [3:0] {
      EXC_NO,
      EXC_INTERRUPT,
      EXC_INST_TLB_REFILL,
      EXC_INST_TLB_INVALID,
      EXC_DATA_TLB_REFILL_LOAD,
      EXC_DATA_TLB_INVALID_LOAD,
      EXC_DATA_TLB_REFILL_STORE,
      EXC_DATA_TLB_INVALID_STORE,
      EXC_SYSCALL,
      EXC_BREAKPOINT,
      EXC_INVALID_INST,
      EXC_OV,
      EXC_ERET
   } Excp_t;
endpackage

module cp0_reg
   import cp0_pkg::*;
#(
   parameter logic [31:0] EBASE_RESET     = 32'h8000_0000,
   parameter logic [31:0] STATUS_RESET    = 32'h0040_0000,
   parameter logic [31:0] STATUS_WMASK    = 32'h0040_FF03,
   parameter int          COUNT_HALF_RATE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [2:0]  wsel_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   input  logic [2:0]  rsel_i,
   output logic [31:0] rdata_o,
   input  logic [5:0]  int_i,
   input  Excp_t       exception_type_i,
   input  logic [31:0] exc_pc_i,
   input  logic        exc_in_delay_slot_i,
   input  logic [31:0] exc_badvaddr_i,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] ebase_o,
   output logic        timer_int_o,
   output logic        int_pending_o
);

   localparam logic [7:0] A_BADV   = {5'd8,  3'd0};
   localparam logic [7:0] A_COUNT  = {5'd9,  3'd0};
   localparam logic [7:0] A_CMP    = {5'd11, 3'd0};
   localparam logic [7:0] A_STATUS = {5'd12, 3'd0};
   localparam logic [7:0] A_CAUSE  = {5'd13, 3'd0};
   localparam logic [7:0] A_EPC    = {5'd14, 3'd0};
   localparam logic [7:0] A_EBASE  = {5'd15, 3'd1};

   logic [31:0] status, cause, epc, ebase, badvaddr, count, compare;
   logic        phase, timer_int;
   logic [7:0]  waddr, raddr;
   logic        exc_take, exc_eret, cnt_inc;

   function automatic logic [4:0] exc_code(input Excp_t e);
      case (e)
         EXC_INST_TLB_REFILL, EXC_INST_TLB_INVALID,
         EXC_DATA_TLB_REFILL_LOAD, EXC_DATA_TLB_INVALID_LOAD: exc_code = 5'd2;
         EXC_DATA_TLB_REFILL_STORE, EXC_DATA_TLB_INVALID_STORE: exc_code = 5'd3;
         EXC_SYSCALL:      exc_code = 5'd8;
         EXC_BREAKPOINT:   exc_code = 5'd9;
         EXC_INVALID_INST: exc_code = 5'd10;
         EXC_OV:           exc_code = 5'd12;
         default:          exc_code = 5'd0;
      endcase
   endfunction

   function automatic logic is_tlb(input Excp_t e);
      is_tlb = (e == EXC_INST_TLB_REFILL)       || (e == EXC_INST_TLB_INVALID) ||
               (e == EXC_DATA_TLB_REFILL_LOAD)  || (e == EXC_DATA_TLB_INVALID_LOAD) ||
               (e == EXC_DATA_TLB_REFILL_STORE) || (e == EXC_DATA_TLB_INVALID_STORE);
   endfunction

   assign waddr    = {waddr_i, wsel_i};
   assign raddr    = {raddr_i, rsel_i};
   assign exc_eret = (exception_type_i == EXC_ERET);
   assign exc_take = (exception_type_i != EXC_NO) && !exc_eret;
   assign cnt_inc  = (COUNT_HALF_RATE != 0) ? phase : 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         status    <= STATUS_RESET;
         cause     <= '0;
         epc       <= '0;
         ebase     <= EBASE_RESET;
         badvaddr  <= '0;
         count     <= '0;
         compare   <= '0;
         phase     <= 1'b0;
         timer_int <= 1'b0;
      end else begin
         if (we_i && waddr == A_COUNT) begin
            count <= wdata_i;
            phase <= 1'b0;
         end else begin
            phase <= ~phase;
            if (cnt_inc) count <= count + 32'd1;
         end

         if (we_i && waddr == A_CMP) compare <= wdata_i;

         // Clearing through a Compare write has priority over a same-cycle match.
         if (we_i && waddr == A_CMP)
            timer_int <= 1'b0;
         else if (count == compare && compare != 32'd0)
            timer_int <= 1'b1;

         cause[15:10] <= {int_i[5] | timer_int, int_i[4:0]};
         if (we_i && waddr == A_CAUSE) cause[9:8] <= wdata_i[9:8];

         if (we_i && waddr == A_STATUS)
            status <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
         if (we_i && waddr == A_EPC) epc <= wdata_i;
         if (we_i && waddr == A_EBASE) ebase <= {2'b10, wdata_i[29:12], 12'h000};

         // Placed after the mtc0 updates so hardware wins on shared fields.
         if (exc_take) begin
            if (!status[1]) begin
               epc       <= exc_in_delay_slot_i ? exc_pc_i - 32'd4 : exc_pc_i;
               cause[31] <= exc_in_delay_slot_i;
            end
            status[1]  <= 1'b1;
            cause[6:2] <= exc_code(exception_type_i);
            if (is_tlb(exception_type_i)) badvaddr <= exc_badvaddr_i;
         end else if (exc_eret) begin
            status[1] <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      case (raddr)
         A_BADV:   rdata_o = badvaddr;
         A_COUNT:  rdata_o = count;
         A_CMP:    rdata_o = compare;
         A_STATUS: rdata_o = status;
         A_CAUSE:  rdata_o = cause;
         A_EPC:    rdata_o = epc;
         A_EBASE:  rdata_o = ebase;
         default:  rdata_o = '0;
      endcase
   end

   assign status_o      = status;
   assign cause_o       = cause;
   assign epc_o         = epc;
   assign ebase_o       = ebase;
   assign timer_int_o   = timer_int;
   assign int_pending_o = status[0] & ~status[1] & ~status[2] &
                          (|(cause[15:8] & status[15:8]));

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: register-access vector table plus timer,
// exception, count and reset sequences with hand-computed expectations.
module tb_cp0_reg;
   import cp0_pkg::*;

   logic        clk, rst, we_i, exc_in_delay_slot_i;
   logic [4:0]  waddr_i, raddr_i;
   logic [2:0]  wsel_i, rsel_i;
   logic [31:0] wdata_i, rdata_o, exc_pc_i, exc_badvaddr_i;
   logic [31:0] status_o, cause_o, epc_o, ebase_o;
   logic [5:0]  int_i;
   logic        timer_int_o, int_pending_o;
   Excp_t       exception_type_i;

   int n_chk = 0;
   int n_fail = 0;

   cp0_reg dut (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wsel_i(wsel_i),
      .wdata_i(wdata_i), .raddr_i(raddr_i), .rsel_i(rsel_i), .rdata_o(rdata_o),
      .int_i(int_i), .exception_type_i(exception_type_i), .exc_pc_i(exc_pc_i),
      .exc_in_delay_slot_i(exc_in_delay_slot_i), .exc_badvaddr_i(exc_badvaddr_i),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o),
      .timer_int_o(timer_int_o), .int_pending_o(int_pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  waddr;
      logic [2:0]  wsel;
      logic [31:0] wdata;
      logic [4:0]  raddr;
      logic [2:0]  rsel;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; wsel_i = s; wdata_i = d;
      step();
      we_i = 1'b0;
   endtask

   task automatic mfc0_chk(input string name, input logic [4:0] a, input logic [2:0] s,
                           input logic [31:0] exp);
      raddr_i = a; rsel_i = s;
      #1;
      chk(name, rdata_o, exp);
   endtask

   task automatic excp(input Excp_t e, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bv);
      exception_type_i = e; exc_pc_i = pc; exc_in_delay_slot_i = ds; exc_badvaddr_i = bv;
      step();
      exception_type_i = EXC_NO;
   endtask

   initial begin
      rst = 1'b0; we_i = 1'b0; waddr_i = '0; wsel_i = '0; wdata_i = '0;
      raddr_i = '0; rsel_i = '0; int_i = '0; exception_type_i = EXC_NO;
      exc_pc_i = '0; exc_in_delay_slot_i = 1'b0; exc_badvaddr_i = '0;

      vecs[0]  = '{5'd12, 3'd0, 32'hFFFF_FFFF, 5'd12, 3'd0, 32'h0040_FF03};
      vecs[1]  = '{5'd15, 3'd1, 32'h0000_0000, 5'd15, 3'd1, 32'h8000_0000};
      vecs[2]  = '{5'd15, 3'd1, 32'hFFFF_FFFF, 5'd15, 3'd1, 32'hBFFF_F000};
      vecs[3]  = '{5'd12, 3'd0, 32'h0000_0000, 5'd12, 3'd0, 32'h0000_0000};
      vecs[4]  = '{5'd7,  3'd0, 32'h0000_DEAD, 5'd7,  3'd0, 32'h0000_0000};
      vecs[5]  = '{5'd14, 3'd0, 32'h1234_5678, 5'd14, 3'd0, 32'h1234_5678};
      vecs[6]  = '{5'd15, 3'd0, 32'h0000_0000, 5'd15, 3'd1, 32'hBFFF_F000};
      vecs[7]  = '{5'd13, 3'd0, 32'hFFFF_FFFF, 5'd13, 3'd0, 32'h0000_0300};
      vecs[8]  = '{5'd13, 3'd0, 32'h0000_0000, 5'd13, 3'd0, 32'h0000_0000};
      vecs[9]  = '{5'd11, 3'd0, 32'h0000_0055, 5'd11, 3'd0, 32'h0000_0055};
      vecs[10] = '{5'd11, 3'd0, 32'h0000_0000, 5'd11, 3'd0, 32'h0000_0000};
      vecs[11] = '{5'd8,  3'd0, 32'h0000_FFFF, 5'd8,  3'd0, 32'h0000_0000};

      // reset
      step(); step();
      chk("rst_status", status_o, 32'h0040_0000);
      chk("rst_ebase", ebase_o, 32'h8000_0000);
      chk("rst_epc", epc_o, 32'h0);
      chk("rst_cause", cause_o, 32'h0);
      chk("rst_timer", {31'b0, timer_int_o}, 32'h0);
      chk("rst_intpend", {31'b0, int_pending_o}, 32'h0);
      mfc0_chk("rst_count", 5'd9, 3'd0, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         mtc0(vecs[i].waddr, vecs[i].wsel, vecs[i].wdata);
         mfc0_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].rsel, vecs[i].exp);
      end

      // same-cycle read returns the old value
      raddr_i = 5'd14; rsel_i = 3'd0;
      we_i = 1'b1; waddr_i = 5'd14; wsel_i = 3'd0; wdata_i = 32'hAAAA_0000;
      #1;
      chk("rd_old_epc", rdata_o, 32'h1234_5678);
      step();
      we_i = 1'b0;
      chk("rd_new_epc", rdata_o, 32'hAAAA_0000);

      // timer: Compare=10, Count=0, IE=1, IM7=1
      mtc0(5'd12, 3'd0, 32'h0000_8001);
      mtc0(5'd11, 3'd0, 32'd10);
      mtc0(5'd9, 3'd0, 32'd0);
      for (int i = 0; i < 20; i++) step();
      chk("tmr_pre", {31'b0, timer_int_o}, 32'h0);
      mfc0_chk("tmr_count10", 5'd9, 3'd0, 32'd10);
      step();
      chk("tmr_set", {31'b0, timer_int_o}, 32'h1);
      chk("tmr_ip7_lag", {31'b0, cause_o[15]}, 32'h0);
      step();
      chk("tmr_ip7", {31'b0, cause_o[15]}, 32'h1);
      chk("tmr_intpend", {31'b0, int_pending_o}, 32'h1);
      chk("tmr_hold", {31'b0, timer_int_o}, 32'h1);
      mtc0(5'd11, 3'd0, 32'd10);
      chk("tmr_clr", {31'b0, timer_int_o}, 32'h0);
      step();
      chk("tmr_ip7_clr", {31'b0, cause_o[15]}, 32'h0);
      chk("tmr_intpend_clr", {31'b0, int_pending_o}, 32'h0);

      // set and clear in the same cycle: clear wins
      mtc0(5'd9, 3'd0, 32'd10);
      mtc0(5'd11, 3'd0, 32'd10);
      chk("tmr_clr_wins", {31'b0, timer_int_o}, 32'h0);
      step();
      chk("tmr_reset", {31'b0, timer_int_o}, 32'h1);
      mtc0(5'd11, 3'd0, 32'd0);
      chk("tmr_clr2", {31'b0, timer_int_o}, 32'h0);
      step();

      // external interrupt into Cause.IP, masked by IM
      int_i = 6'b000001;
      step();
      chk("ip2", {24'b0, cause_o[15:8]}, 32'h0000_0004);
      chk("ip2_masked", {31'b0, int_pending_o}, 32'h0);
      int_i = '0;
      step();

      // syscall in delay slot, then nested overflow
      excp(EXC_SYSCALL, 32'hBFC0_0104, 1'b1, 32'h0);
      chk("sys_epc", epc_o, 32'hBFC0_0100);
      chk("sys_cause", cause_o, 32'h8000_0020);
      chk("sys_status", status_o, 32'h0000_8003);
      excp(EXC_OV, 32'h8000_0000, 1'b0, 32'h0);
      chk("ov_epc", epc_o, 32'hBFC0_0100);
      chk("ov_cause", cause_o, 32'h8000_0030);

      // ERET with same-cycle mtc0 Status setting EXL
      we_i = 1'b1; waddr_i = 5'd12; wsel_i = 3'd0; wdata_i = 32'h0000_0002;
      excp(EXC_ERET, 32'h0, 1'b0, 32'h0);
      we_i = 1'b0;
      chk("eret_status", status_o, 32'h0000_0000);

      excp(EXC_DATA_TLB_REFILL_STORE, 32'h0040_0010, 1'b0, 32'h1234_5678);
      mfc0_chk("tlb_badv", 5'd8, 3'd0, 32'h1234_5678);
      chk("tlb_cause", cause_o, 32'h0000_000C);
      chk("tlb_epc", epc_o, 32'h0040_0010);
      chk("tlb_status", status_o, 32'h0000_0002);

      // Count wrap and write during an increment cycle
      mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
      raddr_i = 5'd9; rsel_i = 3'd0;
      step();
      chk("cnt_hold", rdata_o, 32'hFFFF_FFFF);
      step();
      chk("cnt_wrap", rdata_o, 32'h0);
      step();
      mtc0(5'd9, 3'd0, 32'd5);
      chk("cnt_wr5", rdata_o, 32'd5);
      step();
      chk("cnt_hold5", rdata_o, 32'd5);
      step();
      chk("cnt_6", rdata_o, 32'd6);

      // reset mid-operation
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mrst_status", status_o, 32'h0040_0000);
      chk("mrst_cause", cause_o, 32'h0);
      chk("mrst_epc", epc_o, 32'h0);
      mfc0_chk("mrst_count", 5'd9, 3'd0, 32'h0);
      mfc0_chk("mrst_badv", 5'd8, 3'd0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
